mod_exp_ctrl_rl: RTL and testbench

Right-to-left square-and-multiply modular exponentiation sequencer: computes result = base^exp mod m by issuing a chain of modular multiplications to one external interleaved modular multiplier. It is the initiator side of the multiplier's enable_p / done_irq_p pulse handshake. It owns operand registers and the exponent scan, and it exposes the same start-pulse / done-pulse handshake upward to the host.

---
 rtl/mod_exp_ctrl_rl_pkg.sv | 28 ++
 rtl/mod_exp_ctrl_rl_if.sv | 30 +++
 rtl/mod_exp_ctrl_rl.sv | 132 +++++++++++++
 tb/tb_mod_exp_ctrl_rl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mod_exp_ctrl_rl_pkg.sv
// Shared definitions for the modular-exponentiation sequencers: state encoding
// and the LSB-first exponent scan/termination rule.
package mod_exp_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_MUL_ISSUE = 3'd2,
    S_MUL_WAIT  = 3'd3,
    S_SQR_ISSUE = 3'd4,
    S_SQR_WAIT  = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  // Bit examined on each step and the shift that consumes it.
  localparam int unsigned SCAN_LSB   = 0;
  localparam int unsigned SCAN_SHIFT = 1;

  // Next step for a remaining exponent: finished, multiply-in, or square only.
  function automatic state_t scan_next(input logic e_is_zero, input logic e_lsb);
    state_t s;
    if (e_is_zero)  s = S_DONE;
    else if (e_lsb) s = S_MUL_ISSUE;
    else            s = S_SQR_ISSUE;
    return s;
  endfunction

endpackage

// File: rtl/mod_exp_ctrl_rl_if.sv
// Host-side and multiplier-side handshake bundles for mod_exp_ctrl_rl.
interface mod_exp_host_if #(
  parameter int unsigned NBITS = 4096,
  parameter int unsigned EBITS = 4096
);
  logic             start_p;
  logic [NBITS-1:0] base;
  logic [EBITS-1:0] exp;
  logic [NBITS-1:0] m;
  logic [NBITS-1:0] result;
  logic             busy;
  logic             done_irq_p;

  modport master (output start_p, base, exp, m, input result, busy, done_irq_p);
  modport slave  (input start_p, base, exp, m, output result, busy, done_irq_p);
endinterface

interface mod_exp_mul_if #(
  parameter int unsigned NBITS = 4096
);
  logic             mul_enable_p;
  logic [NBITS-1:0] mul_a;
  logic [NBITS-1:0] mul_b;
  logic [NBITS-1:0] mul_m;
  logic [NBITS-1:0] mul_y;
  logic             mul_done_irq_p;

  modport master (output mul_enable_p, mul_a, mul_b, mul_m, input mul_y, mul_done_irq_p);
  modport slave  (input mul_enable_p, mul_a, mul_b, mul_m, output mul_y, mul_done_irq_p);
endinterface

// File: rtl/mod_exp_ctrl_rl.sv
// Right-to-left square-and-multiply sequencer driving an external modular multiplier.
// Build option MOD_EXP_ONE_SKIP_EN: replace the first multiply (1 * b) with a copy.
module mod_exp_ctrl_rl
  import mod_exp_pkg::*;
#(
  parameter int unsigned NBITS = 4096,
  parameter int unsigned EBITS = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  mod_exp_host_if.slave host,
  mod_exp_mul_if.master mul
);

  state_t           r_state;
  logic [NBITS-1:0] r_acc;
  logic [NBITS-1:0] r_b;
  logic [EBITS-1:0] r_e;
  logic [NBITS-1:0] r_m;
  logic             r_first_mul;
  logic [NBITS-1:0] r_result;
  logic             r_busy;
  logic             r_done_irq_p;
  logic             r_mul_enable_p;
  logic [NBITS-1:0] r_mul_a;
  logic [NBITS-1:0] r_mul_b;
  logic [NBITS-1:0] r_mul_m;

  logic [EBITS-1:0] w_e_shift;
  logic             w_e_shift_zero;
  state_t           w_mul_exit;

  assign w_e_shift      = r_e >> SCAN_SHIFT;
  assign w_e_shift_zero = (w_e_shift == '0);
  // No trailing square once the top exponent bit has been multiplied in.
  assign w_mul_exit     = w_e_shift_zero ? S_DONE : S_SQR_ISSUE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_b            <= '0;
      r_e            <= '0;
      r_m            <= '0;
      r_first_mul    <= 1'b0;
      r_result       <= '0;
      r_busy         <= 1'b0;
      r_done_irq_p   <= 1'b0;
      r_mul_enable_p <= 1'b0;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
      r_mul_m        <= '0;
    end else begin
      r_mul_enable_p <= 1'b0;
      r_done_irq_p   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_busy <= host.start_p;
          if (host.start_p) begin
            r_acc       <= NBITS'(1);
            r_b         <= host.base;
            r_e         <= host.exp;
            r_m         <= host.m;
            r_first_mul <= 1'b1;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_state <= scan_next(r_e == '0, r_e[SCAN_LSB]);
        end
        S_MUL_ISSUE: begin
`ifdef MOD_EXP_ONE_SKIP_EN
          if (r_first_mul) begin
            r_acc       <= r_b;
            r_first_mul <= 1'b0;
            r_state     <= w_mul_exit;
          end else begin
            r_mul_enable_p <= 1'b1;
            r_mul_a        <= r_acc;
            r_mul_b        <= r_b;
            r_mul_m        <= r_m;
            r_state        <= S_MUL_WAIT;
          end
`else
          r_mul_enable_p <= 1'b1;
          r_mul_a        <= r_acc;
          r_mul_b        <= r_b;
          r_mul_m        <= r_m;
          r_state        <= S_MUL_WAIT;
`endif
        end
        S_MUL_WAIT: begin
          if (mul.mul_done_irq_p) begin
            r_acc       <= mul.mul_y;
            r_first_mul <= 1'b0;
            r_state     <= w_mul_exit;
          end
        end
        S_SQR_ISSUE: begin
          r_mul_enable_p <= 1'b1;
          r_mul_a        <= r_b;
          r_mul_b        <= r_b;
          r_mul_m        <= r_m;
          r_state        <= S_SQR_WAIT;
        end
        S_SQR_WAIT: begin
          if (mul.mul_done_irq_p) begin
            r_b     <= mul.mul_y;
            r_e     <= w_e_shift;
            r_state <= scan_next(w_e_shift_zero, w_e_shift[SCAN_LSB]);
          end
        end
        S_DONE: begin
          // busy stays high through the pulse and drops from IDLE next cycle.
          r_result     <= r_acc;
          r_done_irq_p <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign host.result     = r_result;
  assign host.busy       = r_busy;
  assign host.done_irq_p = r_done_irq_p;
  assign mul.mul_enable_p = r_mul_enable_p;
  assign mul.mul_a        = r_mul_a;
  assign mul.mul_b        = r_mul_b;
  assign mul.mul_m        = r_mul_m;

endmodule

// File: tb/tb_mod_exp_ctrl_rl.sv
// Directed bench for mod_exp_ctrl_rl with a behavioural variable-latency multiplier
// and a result scoreboard.
module tb_mod_exp_ctrl_rl;

  localparam int unsigned NB = 8;
  localparam int unsigned EB = 8;
`ifdef MOD_EXP_ONE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mod_exp_host_if #(.NBITS(NB), .EBITS(EB)) host_if ();
  mod_exp_mul_if  #(.NBITS(NB))             mul_if ();

  mod_exp_ctrl_rl #(.NBITS(NB), .EBITS(EB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (host_if),
    .mul   (mul_if)
  );

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Behavioural multiplier: product is returned 'lat' cycles after the enable cycle.
  int unsigned      lat = 1;
  int unsigned      cnt;
  logic             pending = 1'b0;
  logic             prev_en = 1'b0;
  logic [NB-1:0]    pa, pb, pm;
  logic [NB-1:0]    op_m = '0;
  int unsigned      mul_cnt = 0;
  int unsigned      proto_err = 0;
  int unsigned      bad_m = 0;
  int unsigned      done_cnt = 0;

  always @(negedge clk) begin
    mul_if.mul_done_irq_p = 1'b0;
    if (!rst_n) begin
      pending = 1'b0;
      prev_en = 1'b0;
      mul_if.mul_y = '0;
    end else begin
      if (mul_if.mul_enable_p && (pending || prev_en)) proto_err++;
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          mul_if.mul_y = NB'((32'(pa) * 32'(pb)) % 32'(pm));
          mul_if.mul_done_irq_p = 1'b1;
          pending = 1'b0;
        end
      end
      if (mul_if.mul_enable_p) begin
        mul_cnt++;
        if (mul_if.mul_m !== op_m) bad_m++;
        pa = mul_if.mul_a;
        pb = mul_if.mul_b;
        pm = mul_if.mul_m;
        cnt = lat;
        pending = 1'b1;
      end
      prev_en = mul_if.mul_enable_p;
      if (host_if.done_irq_p) done_cnt++;
    end
  end

  logic [NB-1:0] sb_q[$];

  function automatic logic [NB-1:0] ref_pow(input int unsigned b, input int unsigned e,
                                            input int unsigned mm);
    int unsigned r = 1 % mm;
    for (int unsigned i = 0; i < e; i++) r = (r * b) % mm;
    return NB'(r);
  endfunction

  // Squares = index of top set bit; multiplies = number of set bits.
  function automatic int unsigned exp_muls(input int unsigned e);
    int unsigned n = 0;
    int unsigned top = 0;
    for (int unsigned i = 0; i < EB; i++) begin
      if (e[i]) begin
        n++;
        top = i;
      end
    end
    n = n + top;
    if (SKIP && e != 0) n--;
    return n;
  endfunction

  task automatic start_op(input logic [NB-1:0] b, input logic [EB-1:0] e, input logic [NB-1:0] mm);
    @(negedge clk);
    host_if.base    = b;
    host_if.exp     = e;
    host_if.m       = mm;
    host_if.start_p = 1'b1;
    op_m            = mm;
    sb_q.push_back(ref_pow(b, e, mm));
    @(negedge clk);
    host_if.start_p = 1'b0;
    chk("busy_rise", host_if.busy, 1);
  endtask

  // Entered at a negedge; k counts cycles since the start cycle when called right after start_op.
  task automatic wait_done(input string tag, output int unsigned k);
    logic [NB-1:0] expv;
    k = 1;
    while (!host_if.done_irq_p && k < 3000) begin
      @(negedge clk);
      k++;
    end
    expv = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
    if (!host_if.done_irq_p) begin
      chk({tag, "_done_timeout"}, host_if.done_irq_p, 1);
    end else begin
      chk({tag, "_result"}, host_if.result, expv);
      chk({tag, "_busy_at_done"}, host_if.busy, 1);
      @(negedge clk);
      chk({tag, "_busy_fall"}, host_if.busy, 0);
      chk({tag, "_done_single"}, host_if.done_irq_p, 0);
    end
  endtask

  task automatic run(input string tag, input logic [NB-1:0] b, input logic [EB-1:0] e,
                     input logic [NB-1:0] mm, output int unsigned k);
    int unsigned m0;
    m0 = mul_cnt;
    start_op(b, e, mm);
    wait_done(tag, k);
    chk({tag, "_mul_count"}, mul_cnt - m0, exp_muls(e));
  endtask

  initial begin
    int unsigned k, d0, m0;
    host_if.start_p = 1'b0;
    host_if.base    = '0;
    host_if.exp     = '0;
    host_if.m       = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", host_if.result, 0);
    chk("rst_busy", host_if.busy, 0);
    chk("rst_done", host_if.done_irq_p, 0);
    chk("rst_mul_en", mul_if.mul_enable_p, 0);
    chk("rst_mul_a", mul_if.mul_a, 0);
    chk("rst_mul_b", mul_if.mul_b, 0);
    chk("rst_mul_m", mul_if.mul_m, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", host_if.busy, 0);

    lat = 1;
    run("p2e10", 8'd2, 8'd10, 8'd13, k);
    run("p7e1", 8'd7, 8'd1, 8'd11, k);
    run("p5e0", 8'd5, 8'd0, 8'd13, k);
    chk("p5e0_latency", k, 3);
    run("p250_lat1", 8'd250, 8'd255, 8'd251, k);
    lat = 20;
    run("p250_lat20", 8'd250, 8'd255, 8'd251, k);
    lat = 3;
    run("p3e77", 8'd3, 8'd77, 8'd101, k);

    // Re-pulsed start while busy must not disturb the running operation.
    lat = 5;
    d0 = done_cnt;
    start_op(8'd2, 8'd10, 8'd13);
    repeat (6) @(negedge clk);
    host_if.base    = 8'd3;
    host_if.exp     = 8'd3;
    host_if.m       = 8'd7;
    host_if.start_p = 1'b1;
    @(negedge clk);
    host_if.start_p = 1'b0;
    wait_done("repulse", k);
    repeat (10) @(negedge clk);
    chk("repulse_done_count", done_cnt - d0, 1);
    chk("repulse_idle", host_if.busy, 0);

    // Reset while the first square is outstanding.
    lat = 10;
    d0 = done_cnt;
    start_op(8'd2, 8'd10, 8'd13);
    k = 0;
    while (!mul_if.mul_enable_p && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("abort_issue_seen", mul_if.mul_enable_p, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sb_q.pop_back());
    chk("abort_result", host_if.result, 0);
    chk("abort_busy", host_if.busy, 0);
    chk("abort_done", host_if.done_irq_p, 0);
    chk("abort_mul_en", mul_if.mul_enable_p, 0);
    chk("abort_mul_a", mul_if.mul_a, 0);
    chk("abort_mul_b", mul_if.mul_b, 0);
    chk("abort_mul_m", mul_if.mul_m, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle_busy", host_if.busy, 0);
    lat = 1;
    m0 = mul_cnt;
    run("after_abort", 8'd2, 8'd10, 8'd13, k);
    chk("after_abort_total_muls", mul_cnt - m0, SKIP ? 4 : 5);

    chk("protocol_errors", proto_err, 0);
    chk("operand_m_errors", bad_m, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
